// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane-enable
// patterns and the lane/alignment legality check.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H2 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Lane pattern must be one of the seven supported shapes and sit at the
    // lane position implied by the low address bits.
    function automatic logic be_legal(input logic [1:0] lsb, input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: ok = (be == (BE_B0 << lsb));
            BE_H0, BE_H2:               ok = !lsb[0] && (be == (BE_H0 << lsb));
            BE_W:                       ok = (lsb == 2'b00);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// byte/halfword/word lanes and error responses for illegal accesses.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             h_we;
    logic [31:0]      h_addr;
    logic [3:0]       h_be;
    logic [31:0]      h_wdata;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             a_we;
    logic [31:0]      a_addr;
    logic [3:0]       a_be;
    logic [31:0]      a_wdata;
    logic [32:0]      diff;
    logic             in_range;
    logic             legal;
    logic [IDX_W-1:0] idx;
    logic             enter_resp;

    // With zero wait states the response is formed on the accepting edge, so
    // the access fields come straight from the inputs instead of the holding regs.
    always_comb begin
        a_we    = h_we;
        a_addr  = h_addr;
        a_be    = h_be;
        a_wdata = h_wdata;
        if (state == IDLE) begin
            a_we    = we;
            a_addr  = addr;
            a_be    = be;
            a_wdata = wdata;
        end
    end

    // Borrow bit of the 33-bit difference flags addresses below the base.
    always_comb begin
        diff     = {1'b0, a_addr} - {1'b0, BASE_ADDR};
        in_range = !diff[32] && (diff[31:0] < SPAN);
        legal    = in_range && be_legal(a_addr[1:0], a_be);
        idx      = diff[IDX_W+1:2];
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE && req && WAIT_CYCLES == 0)
            enter_resp = 1'b1;
        else if (state == WAIT && cnt == CNT_W'(1))
            enter_resp = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            h_we    <= 1'b0;
            h_addr  <= '0;
            h_be    <= '0;
            h_wdata <= '0;
            for (int i = 0; i < int'(DEPTH_WORDS); i++)
                mem[i] <= '0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;

            case (state)
                IDLE: begin
                    if (req) begin
                        h_we    <= we;
                        h_addr  <= addr;
                        h_be    <= be;
                        h_wdata <= wdata;
                        cnt     <= CNT_LOAD;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Response and store are committed on the edge that enters RESP.
            if (enter_resp) begin
                ack <= 1'b1;
                err <= !legal;
                if (legal && !a_we)
                    rdata <= mem[idx];
                if (legal && a_we) begin
                    for (int l = 0; l < 4; l++)
                        if (a_be[l])
                            mem[idx][8*l +: 8] <= a_wdata[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboarded bench for dm_responder: three instances with 2, 0 and 3 wait states.
module tb_dm_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] xrd;
        logic        xerr;
        bit          chk;
    } txn_t;

    localparam int MAXLAT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int   wc [3] = '{2, 0, 3};
    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    dm_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .be(be[0]), .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]));
    dm_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .be(be[1]), .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]));
    dm_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .be(be[2]), .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]));

    // Drive one request, release req after the accepting edge, wait for ack.
    task automatic issue(input int k, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         output logic [31:0] ord, output logic oerr,
                         output int lat, output bit low_after);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        @(negedge clk);
        req[k] = 1'b0;
        lat = 1;
        while (ack[k] !== 1'b1 && lat <= MAXLAT) begin
            @(negedge clk);
            lat++;
        end
        ord  = rdata[k];
        oerr = err[k];
        @(negedge clk);
        low_after = (ack[k] === 1'b0 && err[k] === 1'b0 && rdata[k] === 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got ack=%b err=%b rdata=%h expected 0/0/0",
                         k, ack[k], err[k], rdata[k]);
            end
        end
    endtask

    task automatic test_access();
        txn_t tl [13] = '{
            '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1},
            '{1'b1, 32'h0000_0020, 4'b1111, 32'h1234_5678, 32'h0,         1'b0, 1'b0},
            '{1'b1, 32'h0000_0022, 4'b0100, 32'h00AB_0000, 32'h0,         1'b0, 1'b0},
            '{1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h12AB_5678, 1'b0, 1'b1},
            '{1'b1, 32'h0000_0023, 4'b1100, 32'hFFFF_0000, 32'h0,         1'b1, 1'b1},
            '{1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h12AB_5678, 1'b0, 1'b1},
            '{1'b0, 32'h0000_0FFC, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1},
            '{1'b0, 32'h0000_1000, 4'b1111, 32'h0,         32'h0,         1'b1, 1'b1},
            '{1'b0, 32'h0000_0020, 4'b0101, 32'h0,         32'h0,         1'b1, 1'b1},
            '{1'b0, 32'h0000_0021, 4'b0010, 32'h0,         32'h12AB_5678, 1'b0, 1'b1},
            '{1'b0, 32'h0000_0022, 4'b1111, 32'h0,         32'h0,         1'b1, 1'b1},
            '{1'b1, 32'h0000_0FFE, 4'b1100, 32'hCAFE_0000, 32'h0,         1'b0, 1'b0},
            '{1'b0, 32'h0000_0FFC, 4'b1111, 32'h0,         32'hCAFE_0000, 1'b0, 1'b1}
        };
        exp_t        e;
        logic [31:0] ord;
        logic        oerr;
        int          lat;
        bit          low;
        for (int i = 0; i < 13; i++) begin
            sb.push_back('{tl[i].xrd, tl[i].xerr, tl[i].chk});
            issue(0, tl[i].w, tl[i].a, tl[i].b, tl[i].d, ord, oerr, lat, low);
            e = sb.pop_front();
            checks++;
            if (lat !== wc[0] + 1) begin
                failures++;
                $display("FAIL access[%0d] latency: got %0d expected %0d", i, lat, wc[0] + 1);
            end
            checks++;
            if (oerr !== e.err) begin
                failures++;
                $display("FAIL access[%0d] err: got %b expected %b", i, oerr, e.err);
            end
            if (e.chk_rd) begin
                checks++;
                if (ord !== e.rdata) begin
                    failures++;
                    $display("FAIL access[%0d] rdata: got %h expected %h", i, ord, e.rdata);
                end
            end
            checks++;
            if (!low) begin
                failures++;
                $display("FAIL access[%0d] ack_one_cycle: got outputs active after RESP expected idle", i);
            end
        end
    endtask

    task automatic test_back_to_back(input int k);
        exp_t        e;
        int          cyc, last, n, gap, lat;
        logic [31:0] ord;
        logic        oerr;
        bit          low;
        for (int i = 0; i < 3; i++)
            sb.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h100; be[k] = 4'hF;
        wdata[k] = 32'hB0B0_0000 | 32'(k << 8);
        n = 0; cyc = 0; last = 0;
        while (n < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack[k] === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (err[k] !== e.err) begin
                    failures++;
                    $display("FAIL b2b[%0d] store%0d err: got %b expected %b", k, n, err[k], e.err);
                end
                gap = (n == 0) ? wc[k] + 1 : wc[k] + 2;
                checks++;
                if (cyc - last !== gap) begin
                    failures++;
                    $display("FAIL b2b[%0d] ack_spacing%0d: got %0d expected %0d", k, n, cyc - last, gap);
                end
                last = cyc;
                n++;
                if (n < 3) begin
                    addr[k]  = 32'(32'h100 + 4 * n);
                    wdata[k] = 32'hB0B0_0000 | 32'(k << 8) | 32'(n);
                end else begin
                    req[k] = 1'b0;
                end
            end
        end
        req[k] = 1'b0;
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL b2b[%0d] ack_count: got %0d expected 3 (timeout)", k, n);
        end
        sb.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{32'hB0B0_0000 | 32'(k << 8) | 32'(i), 1'b0, 1'b1});
            issue(k, 1'b0, 32'(32'h100 + 4 * i), 4'hF, 32'h0, ord, oerr, lat, low);
            e = sb.pop_front();
            checks++;
            if (ord !== e.rdata || oerr !== e.err) begin
                failures++;
                $display("FAIL b2b[%0d] readback%0d: got %h/%b expected %h/%b",
                         k, i, ord, oerr, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t        e;
        logic [31:0] ord;
        logic        oerr;
        int          lat;
        bit          low, seen;
        logic [31:0] la [2] = '{32'h40, 32'h20};
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; be[0] = 4'hF; wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        req[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_in_wait ack: got ack=1 expected no ack");
        end
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{32'h0, 1'b0, 1'b1});
            issue(0, 1'b0, la[i], 4'hF, 32'h0, ord, oerr, lat, low);
            e = sb.pop_front();
            checks++;
            if (ord !== e.rdata || oerr !== e.err || lat !== wc[0] + 1) begin
                failures++;
                $display("FAIL reset_in_wait load %h: got %h/%b lat %0d expected %h/%b lat %0d",
                         la[i], ord, oerr, lat, e.rdata, e.err, wc[0] + 1);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
        end
        test_reset();
        test_access();
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the MIPS core's load/store port.
- Answers one request at a time on a req/ack handshake, with a programmable number of wait states.
- Supports byte, halfword and word accesses through lane enables.
- Flags misaligned, illegal-lane and out-of-range accesses with an error response instead of touching memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word aligned.
- WAIT_CYCLES, 2: wait-state cycles between acceptance and response; 0 is legal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- be  in  4  byte-lane enables, already shifted to the lane position by the requester.
- wdata  in  32  store data in lane position.
- ack  out  1  one-cycle response strobe.
- rdata  out  32  load data (full word); valid while ack=1.
- err  out  1  error flag; valid while ack=1.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state goes to IDLE; ack=0, err=0, rdata=0; wait counter cleared.
  - all memory words cleared to 0.
  - any pending store is discarded.
  - reset has priority over every other event, including mid-WAIT and mid-RESP.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch we/addr/be/wdata into holding registers and load counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise directly to RESP.
  - If req=0, stay in IDLE.
- WAIT:
  - Decrement counter each cycle; when counter reaches 1, the next state is RESP.
  - Latency from the accepting edge to the first cycle with ack=1 is WAIT_CYCLES+1 cycles.
  - Input changes during WAIT are ignored.
- RESP (exactly one cycle):
  - ack=1; all access decisions use the latched fields.
  - Legal store: memory word is updated only on lanes with be[i]=1; the other lanes are unchanged.
  - Legal load: rdata = the stored word (all four lanes); err=0.
  - Illegal access: err=1, rdata=0, memory unchanged.
  - Next state is always IDLE.
- Outputs outside RESP: ack=0, err=0, rdata=0.
- Requester contract:
  - On the edge where it samples ack=1, the requester deasserts req or presents the next request.
  - req is sampled again at the end of the IDLE cycle, which gives the requester one full cycle.
  - Back-to-back transactions are therefore allowed; the minimum period is WAIT_CYCLES+2 cycles.
- Legality (all conditions must hold):
  - be is one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Single-byte enable: be == 4'b0001 << addr[1:0].
  - Halfword enable: addr[0]=0 and be == 4'b0011 << addr[1:0].
  - Word enable: addr[1:0]=0.
  - BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- Address arithmetic:
  - word index = (addr - BASE_ADDR) >> 2, truncated to clog2(DEPTH_WORDS) bits, and computed only after the range check.
  - The last word (index DEPTH_WORDS-1) is legal; the next address is an error.
  - No wrap-around.
- A store immediately followed by a load to the same word returns the new data. The write completes in RESP and the earliest next read is 2+ cycles later.

Decomposition:
- Shared package dm_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - lane-enable constants BE_B0..BE_B3, BE_H0, BE_H2, BE_W.
  - pure function be_legal(addr[1:0], be).
- No sub-module: FSM, counter, holding registers and memory array stay in one module. The legality check is the package function.

Test Plan:
- reset=0 for 2 cycles, then 1; load from addr 0x0000_0010 with be=1111 -> ack after WAIT_CYCLES+1 cycles, rdata=0, err=0; ack stays low at every other cycle.
- Store word 0x1234_5678 at 0x20, then store byte be=0100, wdata=0x00AB_0000 at 0x22, then load 0x20 -> rdata=0x12AB_5678, err=0.
- Halfword store at addr 0x23 with be=1100 -> err=1, rdata=0; a following load of 0x20 shows the word unchanged.
- Load at BASE_ADDR+4*DEPTH_WORDS-4 -> err=0; load at BASE_ADDR+4*DEPTH_WORDS -> err=1; load with be=0101 -> err=1.
- req held high across 3 back-to-back stores with WAIT_CYCLES=0 -> ack every 2nd cycle, all three words written; repeat the sequence with WAIT_CYCLES=3 -> ack every 5th cycle.
- Accept a store of 0xDEAD_BEEF at 0x40, then assert reset=0 during WAIT -> no ack is produced and a subsequent load of 0x40 returns 0.
